// File: rtl/rr_stream_mux.sv
// rr_stream_mux: N-channel packet-aware stream multiplexer with a one-entry
// registered output. A channel that starts a multi-beat packet keeps the
// grant until its in_last beat is accepted. Arbitration is round-robin
// (MODE=0) or fixed priority with the lowest index winning (MODE=1).
//
// Handshake: on every interface a beat moves only on a rising clk edge where
// valid and ready are both high. Valid never waits for ready. in_ready is
// derived from the output register occupancy, the FSM state and the
// arbitration result only.
module rr_stream_mux #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4,
  parameter int MODE   = 0,
  localparam int CW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH-1:0]       in_last,
  output logic [NUM_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  output logic                    out_last,
  output logic [CW-1:0]           out_ch,
  input  logic                    out_ready,
  output logic                    dbg_state,
  output logic [CW-1:0]           dbg_ptr
);

  localparam logic ST_ARB  = 1'b0;
  localparam logic ST_LOCK = 1'b1;

  logic          state_q;
  logic [CW-1:0] lock_ch_q;
  logic [CW-1:0] ptr_q;

  logic          space;
  logic          arb_found;
  logic [CW-1:0] arb_ch;
  logic          grant_en;
  logic [CW-1:0] grant_ch;
  logic [WIDTH-1:0] sel_data;
  logic          sel_last;
  logic          accept;
  logic [CW-1:0] ptr_next;

  // Channel index base+off, wrapped into 0..NUM_CH-1 (off < NUM_CH).
  function automatic logic [CW-1:0] wrap_idx(input logic [CW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_CH) s = s - NUM_CH;
    return CW'(s);
  endfunction

  // The register can take a beat when empty or when it drains this cycle.
  assign space = !out_valid || out_ready;

  // Policy winner among asserted in_valid (used only in ARB).
  always_comb begin
    arb_found = 1'b0;
    arb_ch    = '0;
    if (MODE == 0) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!arb_found && in_valid[wrap_idx(ptr_q, i)]) begin
          arb_found = 1'b1;
          arb_ch    = wrap_idx(ptr_q, i);
        end
      end
    end else begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (in_valid[i]) begin
          arb_found = 1'b1;
          arb_ch    = CW'(i);
        end
      end
    end
  end

  // In LOCK the locked channel owns the grant even while it is idle.
  always_comb begin
    grant_en = 1'b0;
    grant_ch = '0;
    if (state_q == ST_LOCK) begin
      grant_en = 1'b1;
      grant_ch = lock_ch_q;
    end else begin
      grant_en = arb_found;
      grant_ch = arb_ch;
    end
  end

  // One-hot ready to the granted channel; held low during reset.
  always_comb begin
    in_ready = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      in_ready[k] = rst_n && space && grant_en && (grant_ch == CW'(k));
    end
  end

  // Select data and last of the granted channel.
  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (grant_ch == CW'(k)) begin
        sel_data = in_data[k*WIDTH +: WIDTH];
        sel_last = in_last[k];
      end
    end
  end

  assign accept = |(in_valid & in_ready);

  // Pointer moves just past the channel whose packet has ended.
  always_comb begin
    if (grant_ch == CW'(NUM_CH - 1)) ptr_next = '0;
    else                             ptr_next = grant_ch + CW'(1);
  end

  // Output register: load on accept, clear valid on drain without accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_ch    <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_last  <= sel_last;
      out_ch    <= grant_ch;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // ARB/LOCK state: lock on a non-last beat, unlock on the last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_ARB;
      lock_ch_q <= '0;
    end else if (accept) begin
      if (state_q == ST_ARB && !sel_last) begin
        state_q   <= ST_LOCK;
        lock_ch_q <= grant_ch;
      end else if (state_q == ST_LOCK && sel_last) begin
        state_q <= ST_ARB;
      end
    end
  end

  // Round-robin pointer; stays at 0 under fixed priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (MODE == 0 && accept && sel_last) begin
      ptr_q <= ptr_next;
    end
  end

  assign dbg_state = state_q;
  assign dbg_ptr   = ptr_q;

endmodule
